// File: rtl/data_mem_ctr_pkg.sv
// Shared constants for the data-memory controller: access size and op
// encodings, FSM state encoding, and the alignment-check helper.
package data_mem_ctr_pkg;

    // Access size encodings (func_3[1:0]); 2'b11 is handled as a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Operation encodings
    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } state_t;

    // True when the low address bits are illegal for the access size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis_v;
        case (size)
            SZ_BYTE: mis_v = 1'b0;
            SZ_HALF: mis_v = addr_lo[0];
            default: mis_v = (addr_lo != 2'b00);
        endcase
        return mis_v;
    endfunction

endpackage

// File: rtl/data_mem_ctr_lane_align.sv
// mem_lane_align: purely combinational byte-lane steering. Produces the
// per-byte write enables and lane-replicated store data, and extracts a
// right-aligned, zero-filled load value from the addressed RAM word.
// Low address bits that are illegal for the size are ignored here
// (half uses addr[1] only, word always uses lane 0).
import data_mem_ctr_pkg::*;

module mem_lane_align (
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    // Lane selection for stores and extraction for loads
    always_comb begin
        byte_en    = 4'b0000;
        wdata_lane = 32'h0000_0000;
        rdata_ext  = 32'h0000_0000;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = (rword >> {addr_lo, 3'b000}) & 32'h0000_00FF;
            end
            SZ_HALF: begin
                if (addr_lo[1]) begin
                    byte_en = 4'b1100;
                end else begin
                    byte_en = 4'b0011;
                end
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = (rword >> {addr_lo[1], 4'b0000}) & 32'h0000_FFFF;
            end
            default: begin
                byte_en    = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rword;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_ctr.sv
// data_mem_ctr: data-memory controller for the memory-access stage.
// One load/store per access, configurable wait states, pipeline stall
// until completion, internal word-organised RAM with byte enables.
// Optional build macro: MISALIGN_TRAP_EN adds o_misalign and suppresses
// misaligned stores / zeroes misaligned load data.
import data_mem_ctr_pkg::*;

module data_mem_ctr #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic        i_op,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_size,
    output logic [31:0] o_rdata,
    output logic        o_ready,
    output logic        o_stall
`ifdef MISALIGN_TRAP_EN
    ,
    output logic        o_misalign
`endif
);

    localparam int         IDX_W = $clog2(DEPTH_WORDS);
    localparam int         AW    = IDX_W + 2;
    localparam logic [3:0] WS_L  = WAIT_STATES[3:0];

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      cnt_r;
    logic            op_r;
    logic [AW-1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic [1:0]      size_r;

    logic            acc_op_s;
    logic [AW-1:0]   acc_addr_s;
    logic [31:0]     acc_wdata_s;
    logic [1:0]      acc_size_s;
    logic [IDX_W-1:0] idx_s;

    logic            stall_s;
    logic            commit_s;
    logic            commit_ok_s;
    logic            mis_s;
    logic            we_s;
    logic            ld_s;

    logic [31:0]     rword_s;
    logic [3:0]      byte_en_s;
    logic [31:0]     wdata_lane_s;
    logic [31:0]     rdata_ext_s;

    logic [31:0]     rdata_r;
    logic            ready_r;
    logic            unused_addr_s;

    logic [31:0]     mem_r [DEPTH_WORDS];

    // Address bits above the RAM index are ignored so accesses wrap
    assign unused_addr_s = ^i_addr[31:AW];

    // When committing straight from IDLE (zero wait states) the request
    // has not been latched yet, so the live inputs drive the access
    assign acc_op_s    = (state_r == IDLE) ? i_op              : op_r;
    assign acc_addr_s  = (state_r == IDLE) ? i_addr[AW-1:0]    : addr_r;
    assign acc_wdata_s = (state_r == IDLE) ? i_wdata           : wdata_r;
    assign acc_size_s  = (state_r == IDLE) ? i_size            : size_r;
    assign idx_s       = acc_addr_s[AW-1:2];
    assign rword_s     = mem_r[idx_s];

    mem_lane_align u_align (
        .addr_lo    (acc_addr_s[1:0]),
        .size       (acc_size_s),
        .wdata      (acc_wdata_s),
        .rword      (rword_s),
        .byte_en    (byte_en_s),
        .wdata_lane (wdata_lane_s),
        .rdata_ext  (rdata_ext_s)
    );

`ifdef MISALIGN_TRAP_EN
    assign mis_s = is_misaligned(acc_size_s, acc_addr_s[1:0]);
`else
    assign mis_s = 1'b0;
`endif

    // A commit only counts while out of reset, so an access interrupted by reset never writes
    assign commit_ok_s = commit_s & rst_n;
    assign we_s        = commit_ok_s & (acc_op_s == MEM_STORE) & ~mis_s;
    assign ld_s        = commit_ok_s & (acc_op_s == MEM_LOAD);

    // Next-state, stall and commit decode
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        commit_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (i_req) begin
                    stall_s = 1'b1;
                    if (WS_L == 4'd0) begin
                        state_nxt_s = RESP;
                        commit_s    = 1'b1;
                    end else begin
                        state_nxt_s = WAIT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                stall_s = 1'b1;
                if (cnt_r <= 4'd1) begin
                    state_nxt_s = RESP;
                    commit_s    = 1'b1;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Request latch and wait-state counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 4'd0;
            op_r    <= MEM_LOAD;
            addr_r  <= '0;
            wdata_r <= 32'h0000_0000;
            size_r  <= SZ_BYTE;
        end else if ((state_r == IDLE) && i_req) begin
            cnt_r   <= WS_L;
            op_r    <= i_op;
            addr_r  <= i_addr[AW-1:0];
            wdata_r <= i_wdata;
            size_r  <= i_size;
        end else if (state_r == WAIT) begin
            cnt_r   <= cnt_r - 4'd1;
        end
    end

    // RAM byte-lane writes on the commit edge; contents are not reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            if (byte_en_s[0]) mem_r[idx_s][7:0]   <= wdata_lane_s[7:0];
            if (byte_en_s[1]) mem_r[idx_s][15:8]  <= wdata_lane_s[15:8];
            if (byte_en_s[2]) mem_r[idx_s][23:16] <= wdata_lane_s[23:16];
            if (byte_en_s[3]) mem_r[idx_s][31:24] <= wdata_lane_s[31:24];
        end
    end

    // Load data capture; held across stores and idle cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (ld_s) begin
            rdata_r <= mis_s ? 32'h0000_0000 : rdata_ext_s;
        end
    end

    // Completion pulse, high during the single RESP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
        end else begin
            ready_r <= commit_s;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_r;

    // Misalignment flag, valid alongside the completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= commit_s & mis_s;
        end
    end

    assign o_misalign = misalign_r;
`endif

    assign o_rdata = rdata_r;
    assign o_ready = ready_r;
    assign o_stall = stall_s;

endmodule

// File: doc/data_mem_ctr.md
Name: data_mem_ctr

Overview:
Data-memory controller fed directly by the memory-access stage. Accepts one load/store request per access and performs byte-lane placement for stores and lane extraction for loads. Load data is returned right-aligned, and sign/zero extension stays in the memory-access stage. Holds an internal word-organised RAM, models configurable access latency, and stalls the pipeline until the access completes.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the internal RAM (power of two)
WAIT_STATES, 2, extra cycles between acceptance and completion (0..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  request valid; high while the current instruction is a LOAD/STORE
i_op  in  1  0 = load, 1 = store
i_addr  in  32  byte address
i_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
i_size  in  2  00 byte, 01 half, 10 word, 11 treated as word (func_3[1:0])
o_rdata  out  32  load data, right-aligned, upper bits zero for byte/half
o_ready  out  1  one-cycle completion pulse
o_stall  out  1  pipeline hold request

Behaviour:
- Clock/reset: single clock clk; rst_n asynchronous, active low.
- FSM states: IDLE, WAIT, RESP.
- IDLE with i_req=1:
  - Latch i_op, i_addr, i_wdata and i_size.
  - Load the wait counter with WAIT_STATES.
  - Go to WAIT, or directly to RESP if WAIT_STATES=0.
- WAIT: decrement the counter each cycle. When it is 1, go to RESP on the next edge.
- Commit edge: RAM write and RAM read capture happen on the edge that enters RESP.
- RESP: o_ready=1 for exactly one cycle, then return to IDLE. A new request is considered only from IDLE, so back-to-back accesses have one IDLE cycle between them.
- o_stall (combinational):
  - High when (IDLE && i_req) or WAIT.
  - Low in RESP, so the pipeline advances at the end of the RESP cycle.
- Latency: request seen in cycle N gives o_ready in cycle N+1+WAIT_STATES.
- Word index is addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so accesses wrap modulo RAM size.
- Store lanes:
  - Byte: lane addr[1:0] gets i_wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get i_wdata[15:0].
  - Word: all 4 lanes.
  - Unselected bytes are preserved (per-byte write enables).
- Load extraction:
  - Byte: word >> (8*addr[1:0]), masked to 8 bits.
  - Half: word >> (16*addr[1]), masked to 16 bits.
  - Word: unchanged.
- o_rdata is registered. It is updated only at a load commit and holds its value otherwise; stores leave it unchanged.
- Reset values: state IDLE, counter 0, o_rdata 0, o_ready 0, o_stall follows its equation (0 with i_req low). RAM contents are not reset.
- Reset mid-access: the access is abandoned. If reset asserts before the commit edge, no RAM write occurs.
- i_req dropping while in WAIT is ignored; the latched access completes.

Optional Feature:
- Macro MISALIGN_TRAP_EN.
- Defined:
  - Extra output o_misalign (1 bit, reset 0), valid together with o_ready.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Misaligned store: write suppressed.
  - Misaligned load: o_rdata=0.
  - Timing is unchanged.
- Undefined: no port. Low address bits that are illegal for the size are ignored (half uses addr[1] only, word uses lane 0); the access proceeds normally.

Decomposition:
- Shared constants header: size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), FSM state encodings, op encodings (MEM_LOAD/MEM_STORE).
- One natural sub-module, mem_lane_align: purely combinational. Computes byte enables, shifted write data and extracted read data from addr[1:0] and size.
- FSM, counter and RAM live in data_mem_ctr.

Test Plan:
- WAIT_STATES=2. Store word 0xDEADBEEF at 0x10; reset released, i_req held → o_stall high cycles N..N+2, o_ready at N+3. Load word 0x10 → o_rdata=0xDEADBEEF.
- Store byte 0x5A at 0x13 over 0xDEADBEEF, then load word 0x10 → 0x5AADBEEF. Load byte 0x13 → 0x0000005A.
- Store half 0x1234 at 0x16, load half 0x16 → 0x00001234. Load word 0x14 shows 0x1234 in [31:16], lower half preserved.
- WAIT_STATES=0: back-to-back loads → o_ready every second cycle, o_stall low in each RESP cycle.
- Assert rst_n=0 during WAIT of a store to 0x20 → no write (later load returns the prior value), outputs 0. Address 0x1010 with DEPTH_WORDS=1024 aliases to 0x10.
- MISALIGN_TRAP_EN: store word at 0x11 → o_misalign=1 with o_ready, RAM unchanged. Without the macro, the same store writes word 0x10.
